stimulus_sequencer: RTL

//  Transmit side of the lag test: decides when the on-screen test patch is lit, emits the
//  one-cycle measurement-start pulse that restarts the latency counter, and closes each

---
 rtl/stimulus_sequencer_if.sv | 22 ++
 rtl/stimulus_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/stimulus_sequencer_if.sv
// rtl/stimulus_sequencer_if.sv - frame/sensor inputs and patch/measurement outputs of the lag-test sequencer
interface stimulus_sequencer_if;
    logic        enable;
    logic        frame_start;
    logic        sensor_trigger;
    logic        patch_on;
    logic        measure_start;
    logic        measure_done;
    logic        timeout;
    logic [1:0]  state;
    logic [15:0] done_count;

    modport master (
        output enable, frame_start, sensor_trigger,
        input  patch_on, measure_start, measure_done, timeout, state, done_count
    );

    modport slave (
        input  enable, frame_start, sensor_trigger,
        output patch_on, measure_start, measure_done, timeout, state, done_count
    );
endinterface

// File: rtl/stimulus_sequencer.sv
// rtl/stimulus_sequencer.sv - lag-test patch sequencer: lit/dark periods, measurement start/done/timeout pulses
// Optional SENSOR_HOLDOFF_EN: ignore sensor for HOLDOFF_CYCLES clocks after each measure_start.
module stimulus_sequencer #(
    parameter int FRAMES_ON      = 15,
    parameter int FRAMES_OFF     = 15,
    parameter int TIMEOUT_FRAMES = 60,
    parameter int HOLDOFF_CYCLES = 2700
) (
    input  logic                  clk,
    input  logic                  rst,
    stimulus_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, LIT = 2'd1, DARK = 2'd2} state_t;

    localparam logic [7:0] ON_LIMIT  = 8'(FRAMES_ON);
    localparam logic [7:0] OFF_LIMIT = 8'(FRAMES_OFF);
    localparam logic [7:0] TO_LIMIT  = 8'(TIMEOUT_FRAMES);

    state_t     st;
    logic [7:0] frame_cnt;
    logic       seen;
    logic [7:0] frame_inc;
    logic       accept;
    logic       seen_upd;
    logic       holdoff_clear;

`ifdef SENSOR_HOLDOFF_EN
    localparam logic [11:0] HOLDOFF_LOAD = 12'(HOLDOFF_CYCLES);
    logic [11:0] holdoff_cnt;
    assign holdoff_clear = (holdoff_cnt == 12'd0);
`else
    // Always true; only keeps the holdoff parameter referenced in this build.
    assign holdoff_clear = ((HOLDOFF_CYCLES | 1) != 0);
`endif

    always_comb begin
        frame_inc = (frame_cnt == 8'hFF) ? 8'hFF : frame_cnt + 8'd1;
        accept    = (st == LIT) && bus.sensor_trigger && !seen && holdoff_clear;
        seen_upd  = seen | accept;
    end

    assign bus.state = st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st                <= IDLE;
            frame_cnt         <= 8'd0;
            seen              <= 1'b0;
            bus.patch_on      <= 1'b0;
            bus.measure_start <= 1'b0;
            bus.measure_done  <= 1'b0;
            bus.timeout       <= 1'b0;
            bus.done_count    <= 16'd0;
`ifdef SENSOR_HOLDOFF_EN
            holdoff_cnt       <= 12'd0;
`endif
        end else begin
            bus.measure_start <= 1'b0;
            bus.measure_done  <= 1'b0;
            bus.timeout       <= 1'b0;
`ifdef SENSOR_HOLDOFF_EN
            if (holdoff_cnt != 12'd0) holdoff_cnt <= holdoff_cnt - 12'd1;
`endif
            case (st)
                IDLE: begin
                    bus.patch_on <= 1'b0;
                    if (bus.frame_start && bus.enable) begin
                        st                <= LIT;
                        bus.patch_on      <= 1'b1;
                        bus.measure_start <= 1'b1;
                        frame_cnt         <= 8'd0;
                        seen              <= 1'b0;
`ifdef SENSOR_HOLDOFF_EN
                        holdoff_cnt       <= HOLDOFF_LOAD;
`endif
                    end
                end
                LIT: begin
                    if (accept) begin
                        bus.measure_done <= 1'b1;
                        seen             <= 1'b1;
                        bus.done_count   <= bus.done_count + 16'd1;
                    end
                    // A sensor accepted on this same edge already counts toward leaving LIT.
                    if (bus.frame_start) begin
                        if (!bus.enable) begin
                            st           <= IDLE;
                            bus.patch_on <= 1'b0;
                        end else if (seen_upd && frame_inc >= ON_LIMIT) begin
                            st           <= DARK;
                            bus.patch_on <= 1'b0;
                            frame_cnt    <= 8'd0;
                        end else if (!seen_upd && frame_inc >= TO_LIMIT) begin
                            st           <= DARK;
                            bus.patch_on <= 1'b0;
                            bus.timeout  <= 1'b1;
                            frame_cnt    <= 8'd0;
                        end else begin
                            frame_cnt    <= frame_inc;
                        end
                    end
                end
                DARK: begin
                    bus.patch_on <= 1'b0;
                    if (bus.frame_start) begin
                        if (!bus.enable) begin
                            st <= IDLE;
                        end else if (frame_inc == OFF_LIMIT) begin
                            st                <= LIT;
                            bus.patch_on      <= 1'b1;
                            bus.measure_start <= 1'b1;
                            frame_cnt         <= 8'd0;
                            seen              <= 1'b0;
`ifdef SENSOR_HOLDOFF_EN
                            holdoff_cnt       <= HOLDOFF_LOAD;
`endif
                        end else begin
                            frame_cnt <= frame_inc;
                        end
                    end
                end
                default: begin
                    st           <= IDLE;
                    bus.patch_on <= 1'b0;
                end
            endcase
        end
    end
endmodule
